// File: rtl/msu_data_buffer.sv
// ---------------------------------------------------------------------------
// msu_data_buffer
//
// Simple dual-port data buffer for the MSU-1 data stream:
// 2^ADDR_WIDTH words x DATA_WIDTH bits, with a default of 16 KiB x 8.
//
// Port A is write-only. The MCU fills it through the program-write path.
// Port B is read-only. The MSU register logic reads it through its
// auto-incrementing data-port address. Both ports share clkin.
//
// Ports
//   clkin  : system clock. Every port samples on the rising edge.
//   rst_n  : asynchronous, active-low reset. It clears only the read register
//            and blocks writes while it is low. Storage contents are retained.
//   wea    : port A write enable, active-high.
//   addra  : port A write address.
//   dina   : port A write data.
//   addrb  : port B read address. There is no read enable; this port reads
//            on every edge.
//   doutb  : port B registered read data. It shows mem[addrb] one clock
//            after addrb is sampled.
//
// Read/write interaction
//   When wea=1 and addra==addrb on the same edge, the read is read-first:
//   doutb returns the old word, and the new word is visible one edge later.
//   This falls out of both processes sampling mem before the non-blocking
//   write lands, which matches the native read-first mode of block RAM.
// ---------------------------------------------------------------------------
module msu_data_buffer #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clkin,
  input  logic                  rst_n,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] doutb
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // The declaration initialiser sets the power-up contents to zero, so
  // unwritten locations never read as X. Block RAM honours this initial value.
  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1] = '{default: '0};

  logic [DATA_WIDTH-1:0] doutb_q;

  // Write port. This process has no reset term, so it stays a plain RAM write.
  // rst_n only gates the write enable, which blocks writes during reset
  // without ever clearing the array.
  always_ff @(posedge clkin) begin
    if (rst_n && wea) begin
      mem_q[addra] <= dina;
    end
  end

  // Read port output register. This is the only state that the asynchronous
  // reset touches, so it maps onto the RAM's output register.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      doutb_q <= '0;
    end else begin
      doutb_q <= mem_q[addrb];
    end
  end

  assign doutb = doutb_q;

endmodule

// File: tb/tb_msu_data_buffer.sv
// ---------------------------------------------------------------------------
// Testbench for msu_data_buffer.
//
// Stimulus is driven 1 time unit after each rising edge. Outputs are sampled
// at the same point. When a read is launched, its expected doutb value is
// pushed into exp_q. The next tick pops that value and compares it against
// doutb. Asynchronous reset checks push and pop with no clock edge in between.
// ---------------------------------------------------------------------------
module tb_msu_data_buffer;

  localparam int AW = 14;
  localparam int DW = 8;

  // Clock and reset
  logic          clkin = 1'b0;
  logic          rst_n = 1'b1;
  logic          wea   = 1'b0;
  logic [AW-1:0] addra = '0;
  logic [DW-1:0] dina  = '0;
  logic [AW-1:0] addrb = '0;
  logic [DW-1:0] doutb;

  always #5 clkin = ~clkin;

  msu_data_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clkin (clkin),
    .rst_n (rst_n),
    .wea   (wea),
    .addra (addra),
    .dina  (dina),
    .addrb (addrb),
    .doutb (doutb)
  );

  // Scoreboard
  logic [DW-1:0] exp_q[$];
  string         tag_q[$];
  int            n_checks = 0;
  int            n_errors = 0;

  // Reference contents for the random phase. Locations never written read as 0.
  logic [DW-1:0] model [int];

  task automatic expect_val(input string tag, input logic [DW-1:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check_now();
    logic [DW-1:0] e;
    string         t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_checks++;
      assert (doutb === e) else begin
        n_errors++;
        $error("FAIL %s: doutb=%h expected=%h", t, doutb, e);
      end
    end
  endtask

  // Advance one clock edge, then compare the result the DUT produced on it.
  task automatic tick();
    @(posedge clkin);
    #1;
    check_now();
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wea   = 1'b1;
    addra = a;
    dina  = d;
    tick();
    wea   = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [AW-1:0] a,
                         input logic [DW-1:0] e);
    addrb = a;
    expect_val(tag, e);
    tick();
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;

    // Reset asserts asynchronously, so doutb must clear with no clock edge.
    #1;
    rst_n = 1'b0;
    addrb = '0;
    #1;
    expect_val("reset_async_zero", 8'h00);
    check_now();
    // The output stays at 0 across clock edges while reset is held.
    expect_val("reset_hold_zero", 8'h00);
    tick();
    expect_val("reset_hold_zero2", 8'h00);
    tick();

    // Release reset. Power-up contents of address 0 read as 0.
    rst_n = 1'b1;
    do_read("release_mem0", 14'h0000, 8'h00);

    // Write, then read back at both ends of the address range.
    do_write(14'h0000, 8'hA5);
    do_write(14'h3FFF, 8'h5A);
    do_read("rd_0000", 14'h0000, 8'hA5);
    do_read("rd_3FFF", 14'h3FFF, 8'h5A);

    // Streaming read with a one-cycle lag.
    for (int i = 0; i < 16; i++) begin
      do_write(AW'(14'h0100 + i), DW'(8'h10 + i));
    end
    for (int i = 0; i < 16; i++) begin
      do_read("stream", AW'(14'h0100 + i), DW'(8'h10 + i));
    end

    // Collision: the read returns the old word, and the new word follows.
    do_write(14'h0040, 8'h11);
    wea   = 1'b1;
    addra = 14'h0040;
    addrb = 14'h0040;
    dina  = 8'h22;
    expect_val("collision_old", 8'h11);
    tick();
    wea = 1'b0;
    expect_val("collision_new", 8'h22);
    tick();

    // With wea low, the storage is unchanged.
    wea   = 1'b0;
    addra = 14'h0040;
    dina  = 8'hFF;
    tick();
    do_read("wea_low_keep", 14'h0040, 8'h22);

    // Reset preserves the storage contents.
    do_write(14'h1234, 8'h77);
    do_read("pre_reset_1234", 14'h1234, 8'h77);
    #2;
    rst_n = 1'b0;
    #1;
    expect_val("mid_reset_zero", 8'h00);
    check_now();
    // A write attempted during reset must be dropped.
    wea   = 1'b1;
    addra = 14'h1234;
    dina  = 8'h00;
    expect_val("reset_write_zero", 8'h00);
    tick();
    wea   = 1'b0;
    rst_n = 1'b1;
    do_read("post_reset_1234", 14'h1234, 8'h77);

    // Random writes and readbacks in a region the directed steps never touch.
    for (int i = 0; i < 24; i++) begin
      ra = AW'($urandom_range(16'h2000, 16'h203F));
      rd = DW'($urandom_range(0, 255));
      do_write(ra, rd);
      model[int'(ra)] = rd;
    end
    for (int i = 0; i < 24; i++) begin
      ra = AW'($urandom_range(16'h2000, 16'h203F));
      do_read("random_rd", ra, model.exists(int'(ra)) ? model[int'(ra)] : 8'h00);
    end

    // Any expectation still queued means the DUT never produced it.
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: pending=%0d required=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/msu_data_buffer.md
Name: msu_data_buffer

Overview:
- 16 KiB x 8 simple dual-port data buffer for the MSU-1 data stream.
- Port A is write-only. The MCU fills it through the program-write path.
- Port B is read-only. The MSU register logic reads it via its auto-incrementing data-port address.
- Both ports run on one system clock. The read port has a registered output with one-cycle latency.

Parameters:
- ADDR_WIDTH, 14, address bits per port; depth is 2^ADDR_WIDTH (16384).
- DATA_WIDTH, 8, data bits per word.

Ports:
- clkin  input  1  system clock; all ports sample on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- wea  input  1  port A write enable, active-high.
- addra  input  ADDR_WIDTH  port A write address.
- dina  input  DATA_WIDTH  port A write data.
- addrb  input  ADDR_WIDTH  port B read address.
- doutb  output  DATA_WIDTH  port B registered read data.

Behaviour:
- Reset and clock: one clock (clkin). Reset rst_n is asynchronous and active-low.
- Storage: an array of 2^ADDR_WIDTH words of DATA_WIDTH bits. Contents power up as all zeros (initial value).
- Reset does NOT clear the storage.
- Reset output: while rst_n=0, doutb is forced to 0 immediately (asynchronously) and held at 0.
- Reset write blocking: while rst_n=0, writes are ignored.
- Write: on a rising clkin edge with rst_n=1 and wea=1, mem[addra] <= dina. With wea=0 the storage is unchanged.
- Write response: no acknowledge. The write is visible to a port-B read sampled on the following edge or later.
- Read: on every rising clkin edge with rst_n=1, doutb <= mem[addrb]. Latency is exactly 1 clock from addrb sampled to doutb valid.
- Read enable: there is none. doutb tracks addrb continuously with the 1-cycle delay and holds between edges.
- Collision (wea=1 and addra==addrb on the same edge): doutb returns the OLD contents (read-first).
  - The new data appears on a read sampled one edge later.
- Addresses: full-width, no wrap logic inside the block. Address 2^ADDR_WIDTH-1 (0x3FFF) is valid. The caller handles address increment and wrap.
- Reset release: the first doutb update occurs on the first rising edge with rst_n=1. Until then doutb stays 0.
- Reset mid-operation: a write on the same edge that rst_n falls is dropped. Previously written contents are retained through reset.
- No X propagation: unwritten locations read as 0.
- Implementation: must map to block RAM with an output register. The asynchronous reset applies to the output register only.

Test Plan:
- Reset behaviour: assert rst_n=0 with addrb=0 -> doutb=0x00 immediately. Release rst_n -> one edge later doutb=mem[0]=0x00.
- Write then read: write 0xA5 to 0x0000 and 0x5A to 0x3FFF. Next edge set addrb=0x0000 -> doutb=0xA5 after 1 edge. Set addrb=0x3FFF -> doutb=0x5A after 1 edge.
- Streaming read: fill 0x0100..0x010F with 0x10..0x1F. Then step addrb by 1 per clock -> doutb follows with 1-cycle lag: 0x10,0x11,...,0x1F.
- Collision: location 0x0040 holds 0x11. Drive wea=1, addra=addrb=0x0040, dina=0x22 on one edge -> doutb=0x11 on that edge, then 0x22 on the next edge.
- Write enable low: wea=0 with addra=0x0040, dina=0xFF -> a subsequent read of 0x0040 still returns 0x22.
- Reset preserves contents:
  - Write 0x77 to 0x1234, then pulse rst_n low mid-cycle -> doutb=0 during reset.
  - After release, reading 0x1234 returns 0x77.
  - A write attempted while rst_n=0 to 0x1234 with 0x00 has no effect.
